// File: rtl/axi_tdd_pkg.sv
// Shared types for the TDD frame sequencer: state encoding used for status
// readback by the register map, plus default datapath widths.
package axi_tdd_pkg;

    localparam int DEFAULT_REGISTER_WIDTH = 32;
    localparam int DEFAULT_BURST_WIDTH    = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        WAITING = 2'd2,
        RUNNING = 2'd3
    } state_t;

endpackage

// File: rtl/axi_tdd_frame_seq_if.sv
// Control/status bundle between the register map / sync generator and the
// frame sequencer. The master side drives configuration and sync.
interface axi_tdd_frame_seq_if
    import axi_tdd_pkg::*;
#(
    parameter int REGISTER_WIDTH = DEFAULT_REGISTER_WIDTH,
    parameter int BURST_WIDTH    = DEFAULT_BURST_WIDTH
);

    logic                      tdd_enable;
    logic                      tdd_sync;
    logic                      tdd_sync_rst;
    logic [REGISTER_WIDTH-1:0] asy_tdd_startup_delay;
    logic [REGISTER_WIDTH-1:0] asy_tdd_frame_length;
    logic [BURST_WIDTH-1:0]    asy_tdd_burst_count;

    logic [1:0]                tdd_cstate;
    logic [REGISTER_WIDTH-1:0] tdd_counter;
    logic                      tdd_running;
    logic                      tdd_frame_start;
    logic                      tdd_endof_frame;
    logic                      tdd_burst_done;

    modport master (
        output tdd_enable, tdd_sync, tdd_sync_rst,
               asy_tdd_startup_delay, asy_tdd_frame_length, asy_tdd_burst_count,
        input  tdd_cstate, tdd_counter, tdd_running,
               tdd_frame_start, tdd_endof_frame, tdd_burst_done
    );

    modport slave (
        input  tdd_enable, tdd_sync, tdd_sync_rst,
               asy_tdd_startup_delay, asy_tdd_frame_length, asy_tdd_burst_count,
        output tdd_cstate, tdd_counter, tdd_running,
               tdd_frame_start, tdd_endof_frame, tdd_burst_done
    );

endinterface

// File: rtl/axi_tdd_frame_seq.sv
// TDD frame sequencer: arms on enable, waits for sync, runs an optional startup
// delay and then a finite or endless train of fixed-length frames.
module axi_tdd_frame_seq
    import axi_tdd_pkg::*;
#(
    parameter int REGISTER_WIDTH = DEFAULT_REGISTER_WIDTH,
    parameter int BURST_WIDTH    = DEFAULT_BURST_WIDTH
) (
    input  logic               clk,
    input  logic               resetn,
    axi_tdd_frame_seq_if.slave tdd_if
);

    localparam logic [REGISTER_WIDTH-1:0] REG_ONE   = REGISTER_WIDTH'(1);
    localparam logic [BURST_WIDTH-1:0]    BURST_ONE = BURST_WIDTH'(1);

    state_t                    state_q, state_d;
    state_t                    sync_target;
    logic [REGISTER_WIDTH-1:0] counter_q, counter_d;
    logic [BURST_WIDTH-1:0]    burst_q, burst_d;
    logic [REGISTER_WIDTH-1:0] delay_q, delay_d;
    logic [REGISTER_WIDTH-1:0] length_q, length_d;
    logic [BURST_WIDTH-1:0]    count_q, count_d;
    logic                      done_q, done_d;
    logic                      resync;
    logic                      delay_last;
    logic                      frame_last;

    // Compares wrap modulo 2^REGISTER_WIDTH, so a zero frame length is a full-range frame.
    assign sync_target = (delay_q != '0) ? WAITING : RUNNING;
    assign resync      = tdd_if.tdd_sync_rst & tdd_if.tdd_sync;
    assign delay_last  = (counter_q == (delay_q - REG_ONE));
    assign frame_last  = (counter_q == (length_q - REG_ONE));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            counter_q <= '0;
            burst_q   <= '0;
            delay_q   <= '0;
            length_q  <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            burst_q   <= burst_d;
            delay_q   <= delay_d;
            length_q  <= length_d;
            count_q   <= count_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        burst_d   = burst_q;
        delay_d   = delay_q;
        length_d  = length_q;
        count_d   = count_q;
        done_d    = 1'b0;

        // Configuration is only sampled while idle; it is frozen for the whole sequence.
        if (state_q == IDLE) begin
            delay_d  = tdd_if.asy_tdd_startup_delay;
            length_d = tdd_if.asy_tdd_frame_length;
            count_d  = tdd_if.asy_tdd_burst_count;
        end

        if (!tdd_if.tdd_enable) begin
            state_d   = IDLE;
            counter_d = '0;
            burst_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d   = ARMED;
                    counter_d = '0;
                end
                ARMED: begin
                    counter_d = '0;
                    if (tdd_if.tdd_sync) begin
                        state_d = sync_target;
                        burst_d = count_q;
                    end
                end
                WAITING: begin
                    if (resync) begin
                        state_d   = sync_target;
                        counter_d = '0;
                        burst_d   = count_q;
                    end else if (delay_last) begin
                        state_d   = RUNNING;
                        counter_d = '0;
                        burst_d   = count_q;
                    end else begin
                        counter_d = counter_q + REG_ONE;
                    end
                end
                RUNNING: begin
                    // A resync wins over frame/burst completion in the same cycle.
                    if (resync) begin
                        state_d   = sync_target;
                        counter_d = '0;
                        burst_d   = count_q;
                    end else if (frame_last) begin
                        counter_d = '0;
                        if (count_q != '0) begin
                            burst_d = burst_q - BURST_ONE;
                            if (burst_q == BURST_ONE) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                        end
                    end else begin
                        counter_d = counter_q + REG_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign tdd_if.tdd_cstate      = state_q;
    assign tdd_if.tdd_counter     = counter_q;
    assign tdd_if.tdd_running     = (state_q == RUNNING);
    assign tdd_if.tdd_frame_start = (state_q == RUNNING) && (counter_q == '0);
    assign tdd_if.tdd_endof_frame = (state_q == RUNNING) && frame_last;
    assign tdd_if.tdd_burst_done  = done_q;

endmodule

// File: tb/tb_axi_tdd_frame_seq.sv
// Self-checking bench for axi_tdd_frame_seq: directed scenarios plus randomized
// bursts, all compared against a cycle-index timeline model of the sequence.
module tb_axi_tdd_frame_seq;
    import axi_tdd_pkg::*;

    typedef struct packed {
        logic [1:0]  st;
        logic [31:0] cnt;
        logic        run;
        logic        fs;
        logic        eof;
        logic        done;
    } obs_t;

    logic clk;
    logic resetn;
    int   total = 0;
    int   bad   = 0;

    axi_tdd_frame_seq_if #(.REGISTER_WIDTH(32), .BURST_WIDTH(32)) mbus ();
    axi_tdd_frame_seq_if #(.REGISTER_WIDTH(4),  .BURST_WIDTH(4))  wbus ();

    axi_tdd_frame_seq #(.REGISTER_WIDTH(32), .BURST_WIDTH(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .tdd_if (mbus)
    );

    axi_tdd_frame_seq #(.REGISTER_WIDTH(4), .BURST_WIDTH(4)) dut_w (
        .clk    (clk),
        .resetn (resetn),
        .tdd_if (wbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t sampleMain();
        obs_t o;
        o.st   = mbus.tdd_cstate;
        o.cnt  = mbus.tdd_counter;
        o.run  = mbus.tdd_running;
        o.fs   = mbus.tdd_frame_start;
        o.eof  = mbus.tdd_endof_frame;
        o.done = mbus.tdd_burst_done;
        return o;
    endfunction

    function automatic obs_t sampleWide();
        obs_t o;
        o.st   = wbus.tdd_cstate;
        o.cnt  = 32'(wbus.tdd_counter);
        o.run  = wbus.tdd_running;
        o.fs   = wbus.tdd_frame_start;
        o.eof  = wbus.tdd_endof_frame;
        o.done = wbus.tdd_burst_done;
        return o;
    endfunction

    function automatic obs_t stateOnly(logic [1:0] st);
        obs_t o = '0;
        o.st = st;
        return o;
    endfunction

    // Expected outputs j cycles after the sync edge (j=0 is the first cycle after sync),
    // for startup delay d, effective frame length l >= 1, burst count b (0 = endless).
    function automatic obs_t expState(int d, int l, int b, int j);
        obs_t o = '0;
        int k;
        int pos;
        if (j < d) begin
            o.st  = 2'(WAITING);
            o.cnt = 32'(j);
            return o;
        end
        k = j - d;
        if (b != 0 && k >= b * l) begin
            o.st   = (k == b * l) ? 2'(IDLE) : 2'(ARMED);
            o.done = (k == b * l);
            return o;
        end
        pos   = k % l;
        o.st  = 2'(RUNNING);
        o.cnt = 32'(pos);
        o.run = 1'b1;
        o.fs  = (pos == 0);
        o.eof = (pos == l - 1);
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("st=%0d cnt=%0d run=%0b fs=%0b eof=%0b done=%0b",
                         o.st, o.cnt, o.run, o.fs, o.eof, o.done);
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(int d, int l, int b);
        mbus.tdd_enable = 1'b0;
        mbus.tdd_sync   = 1'b0;
        nextCycle();
        mbus.asy_tdd_startup_delay = 32'(d);
        mbus.asy_tdd_frame_length  = 32'(l);
        mbus.asy_tdd_burst_count   = 32'(b);
        mbus.tdd_enable = 1'b1;
        nextCycle();
    endtask

    task automatic pulseSync();
        mbus.tdd_sync = 1'b1;
        nextCycle();
        mbus.tdd_sync = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o;
        resetn = 1'b1;
        mbus.tdd_enable = 1'b0; mbus.tdd_sync = 1'b0; mbus.tdd_sync_rst = 1'b0;
        mbus.asy_tdd_startup_delay = '0; mbus.asy_tdd_frame_length = '0; mbus.asy_tdd_burst_count = '0;
        wbus.tdd_enable = 1'b0; wbus.tdd_sync = 1'b0; wbus.tdd_sync_rst = 1'b0;
        wbus.asy_tdd_startup_delay = '0; wbus.asy_tdd_frame_length = '0; wbus.asy_tdd_burst_count = '0;
        #1 resetn = 1'b0;
        nextCycle();
        nextCycle();
        o = sampleMain(); total++;
        if (o !== obs_t'(0)) begin bad++; $display("[TB] FAIL reset_main got %s want all zero", fmt(o)); end
        o = sampleWide(); total++;
        if (o !== obs_t'(0)) begin bad++; $display("[TB] FAIL reset_wide got %s want all zero", fmt(o)); end
        resetn = 1'b1;
        nextCycle();
        o = sampleMain(); total++;
        if (o !== obs_t'(0)) begin bad++; $display("[TB] FAIL reset_release got %s want all zero", fmt(o)); end
    endtask

    task automatic test_burst();
        obs_t o, e;
        arm(3, 4, 2);
        for (int g = 0; g < 2; g++) begin
            o = sampleMain(); e = stateOnly(2'(ARMED)); total++;
            if (o !== e) begin bad++; $display("[TB] FAIL burst_armed got %s want %s", fmt(o), fmt(e)); end
            nextCycle();
        end
        pulseSync();
        for (int j = 0; j < 14; j++) begin
            o = sampleMain(); e = expState(3, 4, 2, j); total++;
            if (o !== e) begin bad++; $display("[TB] FAIL burst j=%0d got %s want %s", j, fmt(o), fmt(e)); end
            nextCycle();
        end
    endtask

    task automatic test_continuous();
        obs_t o, e;
        arm(0, 1, 0);
        pulseSync();
        for (int j = 0; j < 20; j++) begin
            o = sampleMain(); e = expState(0, 1, 0, j); total++;
            if (o !== e) begin bad++; $display("[TB] FAIL continuous j=%0d got %s want %s", j, fmt(o), fmt(e)); end
            nextCycle();
        end
        mbus.tdd_enable = 1'b0;
        nextCycle();
        o = sampleMain(); total++;
        if (o !== obs_t'(0)) begin bad++; $display("[TB] FAIL continuous_disable got %s want all zero", fmt(o)); end
    endtask

    task automatic test_config_shadow();
        obs_t o, e;
        arm(0, 5, 0);
        pulseSync();
        for (int j = 0; j < 25; j++) begin
            o = sampleMain(); e = expState(0, 5, 0, j); total++;
            if (o !== e) begin bad++; $display("[TB] FAIL shadow_hold j=%0d got %s want %s", j, fmt(o), fmt(e)); end
            if (j == 7) mbus.asy_tdd_frame_length = 32'd9;
            nextCycle();
        end
        mbus.tdd_enable = 1'b0;
        nextCycle();
        mbus.tdd_enable = 1'b1;
        nextCycle();
        pulseSync();
        for (int j = 0; j < 20; j++) begin
            o = sampleMain(); e = expState(0, 9, 0, j); total++;
            if (o !== e) begin bad++; $display("[TB] FAIL shadow_reload j=%0d got %s want %s", j, fmt(o), fmt(e)); end
            nextCycle();
        end
    endtask

    task automatic test_resync();
        obs_t o, e;
        arm(0, 8, 3);
        mbus.tdd_sync_rst = 1'b1;
        pulseSync();
        for (int j = 0; j < 16; j++) begin
            o = sampleMain(); e = expState(0, 8, 3, j); total++;
            if (o !== e) begin bad++; $display("[TB] FAIL resync_pre j=%0d got %s want %s", j, fmt(o), fmt(e)); end
            if (j < 15) nextCycle();
        end
        pulseSync();
        for (int j = 0; j < 26; j++) begin
            o = sampleMain(); e = expState(0, 8, 3, j); total++;
            if (o !== e) begin bad++; $display("[TB] FAIL resync_post j=%0d got %s want %s", j, fmt(o), fmt(e)); end
            nextCycle();
        end
        // Resync landing on the final cycle of the burst must restart, not finish.
        arm(0, 3, 1);
        pulseSync();
        for (int j = 0; j < 3; j++) begin
            o = sampleMain(); e = expState(0, 3, 1, j); total++;
            if (o !== e) begin bad++; $display("[TB] FAIL resync_end_pre j=%0d got %s want %s", j, fmt(o), fmt(e)); end
            if (j < 2) nextCycle();
        end
        pulseSync();
        for (int j = 0; j < 5; j++) begin
            o = sampleMain(); e = expState(0, 3, 1, j); total++;
            if (o !== e) begin bad++; $display("[TB] FAIL resync_end_post j=%0d got %s want %s", j, fmt(o), fmt(e)); end
            nextCycle();
        end
        mbus.tdd_sync_rst = 1'b0;
    endtask

    task automatic test_disable();
        obs_t o, e;
        arm(1, 6, 0);
        pulseSync();
        for (int j = 0; j < 4; j++) begin
            o = sampleMain(); e = expState(1, 6, 0, j); total++;
            if (o !== e) begin bad++; $display("[TB] FAIL disable_pre j=%0d got %s want %s", j, fmt(o), fmt(e)); end
            if (j < 3) nextCycle();
        end
        mbus.tdd_enable = 1'b0;
        nextCycle();
        o = sampleMain(); total++;
        if (o !== obs_t'(0)) begin bad++; $display("[TB] FAIL disable_mid got %s want all zero", fmt(o)); end
        // Disable coinciding with the last cycle of a finite burst: no done pulse.
        arm(0, 3, 1);
        pulseSync();
        nextCycle();
        nextCycle();
        o = sampleMain(); e = expState(0, 3, 1, 2); total++;
        if (o !== e) begin bad++; $display("[TB] FAIL disable_end_pre got %s want %s", fmt(o), fmt(e)); end
        mbus.tdd_enable = 1'b0;
        nextCycle();
        o = sampleMain(); total++;
        if (o !== obs_t'(0)) begin bad++; $display("[TB] FAIL disable_end got %s want all zero", fmt(o)); end
        // Asynchronous reset in the middle of the startup delay.
        arm(5, 4, 1);
        pulseSync();
        nextCycle();
        o = sampleMain(); e = expState(5, 4, 1, 1); total++;
        if (o !== e) begin bad++; $display("[TB] FAIL areset_pre got %s want %s", fmt(o), fmt(e)); end
        #2 resetn = 1'b0;
        #1;
        o = sampleMain(); total++;
        if (o !== obs_t'(0)) begin bad++; $display("[TB] FAIL areset_async got %s want all zero", fmt(o)); end
        mbus.tdd_enable = 1'b0;
        nextCycle();
        resetn = 1'b1;
        nextCycle();
    endtask

    task automatic test_wide_frame();
        obs_t o, e;
        wbus.asy_tdd_startup_delay = 4'd0;
        wbus.asy_tdd_frame_length  = 4'd0;
        wbus.asy_tdd_burst_count   = 4'd1;
        wbus.tdd_enable = 1'b1;
        nextCycle();
        wbus.tdd_sync = 1'b1;
        nextCycle();
        wbus.tdd_sync = 1'b0;
        for (int j = 0; j < 18; j++) begin
            o = sampleWide(); e = expState(0, 16, 1, j); total++;
            if (o !== e) begin bad++; $display("[TB] FAIL wide j=%0d got %s want %s", j, fmt(o), fmt(e)); end
            nextCycle();
        end
        wbus.tdd_enable = 1'b0;
        nextCycle();
    endtask

    task automatic test_random();
        obs_t o, e;
        int d, l, b, gap, n;
        for (int it = 0; it < 12; it++) begin
            d = $urandom_range(0, 6);
            l = $urandom_range(1, 7);
            b = $urandom_range(0, 3);
            gap = $urandom_range(0, 3);
            n = (b == 0) ? d + 3 * l + 2 : d + b * l + 3;
            arm(d, l, b);
            for (int g = 0; g < gap; g++) begin
                o = sampleMain(); e = stateOnly(2'(ARMED)); total++;
                if (o !== e) begin bad++; $display("[TB] FAIL random_armed it=%0d got %s want %s", it, fmt(o), fmt(e)); end
                nextCycle();
            end
            pulseSync();
            for (int j = 0; j < n; j++) begin
                o = sampleMain(); e = expState(d, l, b, j); total++;
                if (o !== e) begin
                    bad++;
                    $display("[TB] FAIL random it=%0d d=%0d l=%0d b=%0d j=%0d got %s want %s",
                             it, d, l, b, j, fmt(o), fmt(e));
                end
                // Stray syncs without sync_rst and config churn must be ignored mid-sequence.
                mbus.tdd_sync = (e.st == 2'(WAITING) || e.st == 2'(RUNNING)) && ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 3) == 0) mbus.asy_tdd_frame_length = 32'($urandom_range(1, 9));
                nextCycle();
            end
            mbus.tdd_sync = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_continuous();
        test_config_shadow();
        test_resync();
        test_disable();
        test_wide_frame();
        test_random();
        mbus.tdd_enable = 1'b0;
        nextCycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
